// File: rtl/psum_column_accumulator.sv
// Column psum accumulator: sums one systolic column's PsumOut stream over K-tile passes,
// then drains the finished rows over valid/ready. Define PSUM_ACC_SAT_EN to saturate on overflow.
module psum_column_accumulator #(
  parameter int WIDTH  = 8,
  parameter int ACC_W  = 2*WIDTH+8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             ASYNC_RST,
  input  logic             SYNC_RST,
  input  logic             PsumValid,
  input  logic [2*WIDTH:0] PsumIn,
  input  logic             FirstPass,
  input  logic             LastPass,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [ACC_W-1:0] OutData,
  output logic             Busy,
  output logic             Overflow
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;        // entries fetched into the output register
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;  // entries handed to the consumer
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              overflow_q, overflow_d;

  logic [ACC_W-1:0]  mem [DEPTH];

  logic              wr_en, eff_first, carry, rd_en, xfer;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  psum_ext, wr_data;

  always_comb begin
    psum_ext  = ACC_W'(PsumIn);
    // The row-0 beat uses the live pass flags; later beats use the held copies.
    eff_first = (state_q == IDLE) ? FirstPass : first_q;
    wr_en     = PsumValid && (state_q != DRAIN) && !SYNC_RST;
    sum       = {1'b0, mem[wr_ptr_q]} + {1'b0, psum_ext};
    carry     = !eff_first && sum[ACC_W];
`ifdef PSUM_ACC_SAT_EN
    wr_data   = eff_first ? psum_ext : (carry ? '1 : sum[ACC_W-1:0]);
`else
    wr_data   = eff_first ? psum_ext : sum[ACC_W-1:0];
`endif
    xfer      = out_valid_q && OutReady;
    rd_en     = (state_q == DRAIN) && (rd_ptr_q != DEPTH_C) && (!out_valid_q || xfer);

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    drain_cnt_d = drain_cnt_q;
    first_d     = first_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;

    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_ROW) ? '0 : wr_ptr_q + ADDR_W'(1);
      if (carry) overflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (PsumValid) begin
          state_d = ACCUM;
          first_d = FirstPass;
          last_d  = LastPass;
        end
      end
      ACCUM: begin
        if (PsumValid && wr_ptr_q == LAST_ROW) state_d = last_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        // Beats arriving while draining are dropped and flagged as a protocol error.
        if (PsumValid) overflow_d = 1'b1;
        if (rd_en) begin
          out_data_d  = mem[rd_ptr_q[ADDR_W-1:0]];
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + CNT_W'(1);
        end else if (xfer) begin
          out_valid_d = 1'b0;
        end
        if (xfer) begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
          if (drain_cnt_q == DEPTH_C - CNT_W'(1)) begin
            state_d     = IDLE;
            rd_ptr_d    = '0;
            drain_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (SYNC_RST) begin
      state_d     = IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      drain_cnt_d = '0;
      first_d     = 1'b0;
      last_d      = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drain_cnt_q <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drain_cnt_q <= drain_cnt_d;
      first_q     <= first_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Buffer contents are defined by FirstPass, so the array carries no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign OutValid = out_valid_q;
  assign OutData  = out_data_q;
  assign Busy     = (state_q != IDLE);
  assign Overflow = overflow_q;

endmodule
